// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the register-file write port

// 5-to-32 one-hot decoder for the write select vector
module dec5to32 (
  input  logic [4:0]  adr,
  output logic [31:0] dec
);

  // one bit per register address
  always_comb begin
    dec = 32'd0;
    dec[adr] = 1'b1;
  end

endmodule

// Two writeback requesters (A = ALU, B = load) share one registered write stage.
module regfile_wr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ZERO_DROP = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqA,
  input  logic [4:0]        AdrA,
  input  logic [DATA_W-1:0] DataA,
  output logic              GntA,
  input  logic              ReqB,
  input  logic [4:0]        AdrB,
  input  logic [DATA_W-1:0] DataB,
  output logic              GntB,
  input  logic              Stall,
  output logic              WrEn,
  output logic [4:0]        WrAdr,
  output logic [DATA_W-1:0] WrData,
  output logic [31:0]       WrDec,
  output logic              PrioB
);

  logic              prio_b_q, prio_b_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              gnt_a, gnt_b;
  logic [4:0]        sel_adr;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       dec_raw;

  // grant: stall blocks everything, a lone requester wins, ties go to the pointer
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!Stall) begin
      if (ReqA && (!ReqB || !prio_b_q)) begin
        gnt_a = 1'b1;
      end else if (ReqB) begin
        gnt_b = 1'b1;
      end
    end
  end

  // mux of the granted side's payload into the write stage
  always_comb begin
    sel_adr  = gnt_b ? AdrB  : AdrA;
    sel_data = gnt_b ? DataB : DataA;
  end

  // next state of the pointer and write stage; stall freezes the stage so a
  // pending write stays visible until the register file can take it
  always_comb begin
    prio_b_d  = prio_b_q;
    wr_en_d   = wr_en_q;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    if (gnt_a) begin
      prio_b_d = 1'b1;
    end else if (gnt_b) begin
      prio_b_d = 1'b0;
    end
    if (!Stall) begin
      if (gnt_a || gnt_b) begin
        wr_adr_d  = sel_adr;
        wr_data_d = sel_data;
        wr_en_d   = !((ZERO_DROP != 0) && (sel_adr == 5'd0));
      end else begin
        wr_en_d = 1'b0;
      end
    end
  end

  // state registers with asynchronous clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prio_b_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= 5'd0;
      wr_data_q <= '0;
    end else begin
      prio_b_q  <= prio_b_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
    end
  end

  dec5to32 u_dec (
    .adr (wr_adr_q),
    .dec (dec_raw)
  );

  assign GntA   = gnt_a;
  assign GntB   = gnt_b;
  assign WrEn   = wr_en_q;
  assign WrAdr  = wr_adr_q;
  assign WrData = wr_data_q;
  assign WrDec  = dec_raw & {32{wr_en_q}};
  assign PrioB  = prio_b_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed vector bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ReqA, ReqB, Stall;
  logic [4:0]  AdrA, AdrB;
  logic [31:0] DataA, DataB;
  logic        GntA, GntB, WrEn, PrioB;
  logic [4:0]  WrAdr;
  logic [31:0] WrData, WrDec;

  logic        z_GntA, z_GntB, z_WrEn, z_PrioB;
  logic [4:0]  z_WrAdr;
  logic [31:0] z_WrData, z_WrDec;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  regfile_wr_arbiter #(.DATA_W(32), .ZERO_DROP(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqA(ReqA), .AdrA(AdrA), .DataA(DataA), .GntA(GntA),
    .ReqB(ReqB), .AdrB(AdrB), .DataB(DataB), .GntB(GntB),
    .Stall(Stall), .WrEn(WrEn), .WrAdr(WrAdr), .WrData(WrData),
    .WrDec(WrDec), .PrioB(PrioB)
  );

  regfile_wr_arbiter #(.DATA_W(32), .ZERO_DROP(0)) dut_nz (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqA(ReqA), .AdrA(AdrA), .DataA(DataA), .GntA(z_GntA),
    .ReqB(ReqB), .AdrB(AdrB), .DataB(DataB), .GntB(z_GntB),
    .Stall(Stall), .WrEn(z_WrEn), .WrAdr(z_WrAdr), .WrData(z_WrData),
    .WrDec(z_WrDec), .PrioB(z_PrioB)
  );

  typedef struct packed {
    logic        ra;
    logic [4:0]  aa;
    logic [31:0] da;
    logic        rb;
    logic [4:0]  ab;
    logic [31:0] db;
    logic        st;
    logic        ga;
    logic        gb;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wdec;
    logic        pb;
    logic        we_nz;
    logic [31:0] wdec_nz;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ra, input logic [4:0] aa, input logic [31:0] da,
                       input logic rb, input logic [4:0] ab, input logic [31:0] db,
                       input logic st);
    ReqA = ra; AdrA = aa; DataA = da;
    ReqB = rb; AdrB = ab; DataB = db;
    Stall = st;
  endtask

  initial begin
    //           ra    aa     da            rb    ab     db            st    ga    gb    we    wa     wd            wdec          pb    we_nz wdec_nz
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1,       32'h2,        1'b1, 1'b1, 32'h2};
    vecs[3]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'hB2,       32'h4,        1'b0, 1'b1, 32'h4};
    vecs[4]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1,       32'h2,        1'b1, 1'b1, 32'h2};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'hB2,       32'h4,        1'b0, 1'b1, 32'h4};
    vecs[6]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'hB2,       32'h0,        1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h20,       1'b1, 1'b1, 32'h20};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234,     1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1234,     32'h0,        1'b0, 1'b1, 32'h1};
    vecs[10] = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1234,     32'h0,        1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33,       32'h8,        1'b1, 1'b1, 32'h8};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33,       32'h8,        1'b1, 1'b1, 32'h8};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h33,       32'h8,        1'b1, 1'b1, 32'h8};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44,       32'h10,       1'b0, 1'b1, 32'h10};
    vecs[15] = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 32'h2,        1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h44,       32'h0,        1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h2,        1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1,        32'h80,       1'b1, 1'b1, 32'h80};
    vecs[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h2,        32'h80,       1'b0, 1'b1, 32'h80};
    vecs[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h2,        32'h0,        1'b0, 1'b0, 32'h0};

    // reset held with a live request: everything must stay clear
    Rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_wren",  {31'd0, WrEn},  32'd0);
    chk("rst_wradr", {27'd0, WrAdr}, 32'd0);
    chk("rst_wrdata", WrData,        32'd0);
    chk("rst_wrdec",  WrDec,         32'd0);
    chk("rst_priob", {31'd0, PrioB}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    Rst_n = 1'b1;

    // main vector table, one cycle per row
    for (int i = 0; i < NV; i++) begin
      @(posedge Clk);
      #1;
      drive(vecs[i].ra, vecs[i].aa, vecs[i].da, vecs[i].rb, vecs[i].ab, vecs[i].db, vecs[i].st);
      @(negedge Clk);
      chk($sformatf("v%0d_gnta", i),   {31'd0, GntA},  {31'd0, vecs[i].ga});
      chk($sformatf("v%0d_gntb", i),   {31'd0, GntB},  {31'd0, vecs[i].gb});
      chk($sformatf("v%0d_wren", i),   {31'd0, WrEn},  {31'd0, vecs[i].we});
      chk($sformatf("v%0d_wradr", i),  {27'd0, WrAdr}, {27'd0, vecs[i].wa});
      chk($sformatf("v%0d_wrdata", i), WrData,         vecs[i].wd);
      chk($sformatf("v%0d_wrdec", i),  WrDec,          vecs[i].wdec);
      chk($sformatf("v%0d_priob", i),  {31'd0, PrioB}, {31'd0, vecs[i].pb});
      chk($sformatf("v%0d_nz_wren", i),  {31'd0, z_WrEn}, {31'd0, vecs[i].we_nz});
      chk($sformatf("v%0d_nz_wrdec", i), z_WrDec,         vecs[i].wdec_nz);
    end

    // asynchronous reset in the middle of a stall with a write pending
    @(posedge Clk); #1;
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge Clk); #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge Clk);
    chk("stall_wren_pre",  {31'd0, WrEn}, 32'd1);
    chk("stall_wrdec_pre", WrDec,         32'h200);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_wren",  {31'd0, WrEn},  32'd0);
    chk("async_wradr", {27'd0, WrAdr}, 32'd0);
    chk("async_wrdata", WrData,        32'd0);
    chk("async_wrdec",  WrDec,         32'd0);
    chk("async_priob", {31'd0, PrioB}, 32'd0);

    // release between edges; first tie after reset goes to A and lands next cycle
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 1'b0);
    #1;
    chk("post_rst_gnta", {31'd0, GntA}, 32'd1);
    chk("post_rst_gntb", {31'd0, GntB}, 32'd0);
    @(posedge Clk); #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge Clk);
    chk("post_rst_wren",  {31'd0, WrEn},  32'd1);
    chk("post_rst_wradr", {27'd0, WrAdr}, 32'd6);
    chk("post_rst_wrdata", WrData,        32'h66);
    chk("post_rst_priob", {31'd0, PrioB}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
